riscv_ctrl_fsm: RTL and testbench



---
 rtl/riscv_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_riscv_ctrl_fsm.sv | 137 +++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control sequencer for an RV32I subset datapath.
// Decode is captured at ID->EX; strobes come from registered state and decode only.
module riscv_ctrl_fsm #(
  parameter logic [6:0] SW        = 7'b0100011,
  parameter logic [6:0] LW        = 7'b0000011,
  parameter logic [6:0] IMMEDIATE = 7'b0010011,
  parameter logic [6:0] BEQ       = 7'b1100011,
  parameter logic [6:0] RR        = 7'b0110011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NOP = 3'd0,
    C_LW  = 3'd1,
    C_SW  = 3'd2,
    C_BR  = 3'd3,
    C_RR  = 3'd4,
    C_IMM = 3'd5
  } cls_t;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_XOR = 4'b0101;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_SRL = 4'b1000;
  localparam logic [3:0] A_SLL = 4'b1001;
  localparam logic [3:0] A_SRA = 4'b1010;

  state_t     st, nxt;
  cls_t       cls_q, d_cls;
  logic [3:0] alu_q, d_alu, f3_alu;
  logic       src_q, d_src, d_ill;
  logic       f3_ok, br_q;

  logic [6:0] op;
  logic [2:0] f3;
  logic       alt;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign alt = instr[30];

  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    f3_ok  = 1'b1;
    f3_alu = A_ADD;
    case (f3)
      3'b000:  f3_alu = alt ? A_SUB : A_ADD;
      3'b111:  f3_alu = A_AND;
      3'b110:  f3_alu = A_OR;
      3'b100:  f3_alu = A_XOR;
      3'b010:  f3_alu = A_SLT;
      3'b001:  f3_alu = A_SLL;
      3'b101:  f3_alu = alt ? A_SRA : A_SRL;
      default: f3_ok  = 1'b0;
    endcase
  end

  // Unsupported encodings fall through as a NOP that still retires.
  always_comb begin
    d_cls = C_NOP;
    d_alu = A_ADD;
    d_src = 1'b0;
    d_ill = 1'b0;
    unique case (1'b1)
      (op == LW): begin
        d_cls = C_LW;
        d_src = 1'b1;
      end
      (op == SW): begin
        d_cls = C_SW;
        d_src = 1'b1;
      end
      (op == BEQ): begin
        d_cls = C_BR;
        d_alu = A_SUB;
      end
      (op == RR): begin
        if (f3_ok) begin
          d_cls = C_RR;
          d_alu = f3_alu;
        end else begin
          d_ill = 1'b1;
        end
      end
      (op == IMMEDIATE): begin
        if (f3_ok) begin
          d_cls = C_IMM;
          d_src = 1'b1;
          d_alu = (f3 == 3'b000) ? A_ADD : f3_alu;
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_comb begin
    nxt = st;
    case (st)
      S_IF:  nxt = S_ID;
      S_ID:  nxt = S_EX;
      S_EX:  nxt = S_MEM;
      S_MEM: begin
        if ((cls_q == C_LW || cls_q == C_SW) && !mem_ready)
          nxt = S_MEM;
        else
          nxt = S_WB;
      end
      S_WB:  nxt = S_IF;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= S_IF;
      cls_q <= C_NOP;
      alu_q <= 4'b0000;
      src_q <= 1'b0;
      br_q  <= 1'b0;
    end else begin
      st <= nxt;
      if (st == S_ID) begin
        cls_q <= d_cls;
        alu_q <= d_alu;
        src_q <= d_src;
      end
      if (st == S_EX)
        br_q <= (cls_q == C_BR) & Zero;
    end
  end

  assign state    = st;
  assign ALUCtrl  = alu_q;
  assign ALUSrc   = src_q;
  assign illegal  = (st == S_ID) & d_ill;
  assign MemRead  = (st == S_MEM) & (cls_q == C_LW);
  assign MemWrite = (st == S_MEM) & (cls_q == C_SW);
  assign RegWrite = (st == S_WB) &
                    (cls_q == C_LW || cls_q == C_RR ||
                     cls_q == C_IMM);
  assign MemToReg = (st == S_WB) & (cls_q == C_LW);
  assign loadPC   = (st == S_WB);
  assign PCSrc    = (st == S_WB) & br_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed bench for riscv_ctrl_fsm: per-cycle output vectors
// against hand-computed expectations for each instruction class.
module tb_riscv_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ALUSrc, RegWrite, MemToReg, MemRead;
  logic        MemWrite, loadPC, PCSrc, illegal;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  logic [3:0] palu = 4'b0000;
  logic       psrc = 1'b0;

  riscv_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr),
    .Zero(Zero), .mem_ready(mem_ready),
    .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
    .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .loadPC(loadPC), .PCSrc(PCSrc),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // {state, ALUSrc, ALUCtrl, RegWrite, MemToReg,
  //  MemRead, MemWrite, loadPC, PCSrc, illegal}
  logic [14:0] outs;
  assign outs = {state, ALUSrc, ALUCtrl, RegWrite,
                 MemToReg, MemRead, MemWrite,
                 loadPC, PCSrc, illegal};

  task automatic chk(input string tag,
                     input logic [14:0] exp);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, outs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] ins,
                     input logic [3:0] alu,
                     input logic src, rw, m2r, mr, mw,
                     input logic pcs, ill,
                     input logic z_ex, z_mem,
                     input int waits,
                     input logic rdy0);
    instr = ins;
    chk({tag, ".if"}, {3'd0, psrc, palu, 7'b0});
    tick();
    chk({tag, ".id"}, {3'd1, psrc, palu, 6'b0, ill});
    Zero = z_ex;
    mem_ready = (waits > 0) ? 1'b0 : rdy0;
    tick();
    chk({tag, ".ex"}, {3'd2, src, alu, 7'b0});
    tick();
    Zero = z_mem;
    for (int i = 0; i < waits; i++) begin
      chk({tag, ".memw"},
          {3'd3, src, alu, 2'b00, mr, mw, 3'b000});
      tick();
    end
    if (waits > 0) mem_ready = 1'b1;
    chk({tag, ".mem"},
        {3'd3, src, alu, 2'b00, mr, mw, 3'b000});
    tick();
    mem_ready = 1'b0;
    chk({tag, ".wb"},
        {3'd4, src, alu, rw, m2r, 2'b00, 1'b1, pcs, 1'b0});
    tick();
    psrc = src;
    palu = alu;
  endtask

  initial begin
    #12;
    chk("reset", 15'h0);
    @(negedge clk);
    rst = 1'b0;

    // tag, instr, alu, src, rw, m2r, mr, mw, pcs, ill,
    // z_ex, z_mem, waits, rdy0
    run("add",  32'h002081B3, 4'b0010, 0, 1, 0, 0, 0, 0, 0,
        0, 0, 0, 0);
    run("sub",  32'h402081B3, 4'b0110, 0, 1, 0, 0, 0, 0, 0,
        0, 0, 0, 0);
    run("srai", 32'h4030D093, 4'b1010, 1, 1, 0, 0, 0, 0, 0,
        0, 0, 0, 0);
    run("lw",   32'h00812283, 4'b0010, 1, 1, 1, 1, 0, 0, 0,
        0, 0, 3, 0);
    run("sw",   32'h00512423, 4'b0010, 1, 0, 0, 0, 1, 0, 0,
        0, 0, 0, 1);
    run("beqt", 32'h00208463, 4'b0110, 0, 0, 0, 0, 0, 1, 0,
        1, 0, 0, 0);
    run("beqn", 32'h00208463, 4'b0110, 0, 0, 0, 0, 0, 0, 0,
        0, 1, 0, 0);
    run("ill",  32'h0000007F, 4'b0010, 0, 0, 0, 0, 0, 0, 1,
        0, 0, 0, 0);

    // Abort a load while it waits in MEM.
    instr = 32'h00812283;
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("rstlw.mem1", {3'd3, 1'b1, 4'b0010, 2'b00, 1'b1, 4'b0});
    tick();
    chk("rstlw.mem2", {3'd3, 1'b1, 4'b0010, 2'b00, 1'b1, 4'b0});
    #2;
    rst = 1'b1;
    #1;
    chk("rstlw.async", 15'h0);
    @(negedge clk);
    chk("rstlw.held", 15'h0);
    rst = 1'b0;
    tick();
    chk("rstlw.restart", {3'd1, 12'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
